// File: rtl/sub_bytes.sv
// sub_bytes -- registered AES SubBytes stage.
//
// Maps each of the 16 bytes of a 128-bit AES state through the FIPS-197
// S-box and registers the result, giving a fixed one-cycle latency at one
// state per cycle. The 16 byte lanes are independent and identical.
//
// Optional build macro: SUB_BYTES_INV_EN
//   defined   -> adds port inv and the inverse S-box table; inv is sampled
//                together with in_valid and selects the inverse mapping.
//   undefined -> forward S-box only, no inv port.
//
// Ports:
//   clk        input   1    rising-edge clock
//   rst_n      input   1    synchronous active-low reset
//   in_valid   input   1    state_in holds a valid state this cycle
//   state_in   input   128  byte k = bits [8k+7:8k]
//   inv        input   1    (SUB_BYTES_INV_EN only) 1 = inverse S-box
//   out_valid  output  1    state_out carries a new result this cycle
//   state_out  output  128  substituted state, same byte order as state_in
module sub_bytes (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [127:0] state_in,
`ifdef SUB_BYTES_INV_EN
  input  logic         inv,
`endif
  output logic         out_valid,
  output logic [127:0] state_out
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

`ifdef SUB_BYTES_INV_EN
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };
`endif

  // Stage 0: combinational byte substitution of the incoming state
  logic [127:0] sub_p0;

  always_comb begin
    sub_p0 = '0;
    for (int k = 0; k < 16; k++) begin
`ifdef SUB_BYTES_INV_EN
      sub_p0[8*k +: 8] = inv ? INV_SBOX[state_in[8*k +: 8]] : SBOX[state_in[8*k +: 8]];
`else
      sub_p0[8*k +: 8] = SBOX[state_in[8*k +: 8]];
`endif
    end
  end

  // Stage 1: output register; data loads only on valid so idle-cycle
  // garbage (including X) on state_in never reaches state_out
  logic [127:0] state_p1;
  logic         vld_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) state_p1 <= sub_p0;
    end
  end

  assign state_out = state_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_sub_bytes.sv
// tb_sub_bytes -- self-checking bench for sub_bytes.
// The reference S-box is derived arithmetically (GF(2^8) inverse plus affine
// transform); the inverse table is the preimage of that forward table.
// Build with SUB_BYTES_INV_EN defined to also cover the inverse mapping.
module tb_sub_bytes;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] state_in;
  logic         inv_b;
  logic         out_valid;
  logic [127:0] state_out;

  int total = 0;
  int bad   = 0;

  logic [7:0] ref_fwd [256];
  logic [7:0] ref_inv [256];

  logic [127:0] exp_state;
  logic         exp_vld;

  sub_bytes dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .state_in  (state_in),
`ifdef SUB_BYTES_INV_EN
    .inv       (inv_b),
`endif
    .out_valid (out_valid),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] model_sbox(input logic [7:0] x);
    logic [7:0] y = 8'h00;
    if (x != 8'h00)
      for (int c = 1; c < 256; c++)
        if (gmul(x, 8'(c)) == 8'h01) y = 8'(c);
    return y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] model_state(input logic [127:0] s, input logic use_inv);
    logic [127:0] r;
    for (int k = 0; k < 16; k++)
      r[8*k +: 8] = use_inv ? ref_inv[s[8*k +: 8]] : ref_fwd[s[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [127:0] s, input logic iv);
    in_valid = v;
    state_in = s;
    inv_b    = iv;
  endtask

  localparam logic [127:0] V1_IN  = 128'h19a09ae93df4c6f8e3e28d48be2b2a08;
  localparam logic [127:0] V1_OUT = 128'hd4e0b81e27bfb44111985d52aef1e530;
  localparam logic [127:0] V2_IN  = 128'ha4686b029c9f5b6a7f35ea50f22b4349;
  localparam logic [127:0] V2_OUT = 128'h49457f77dedb3902d296875389f11a3b;

  initial begin
    for (int i = 0; i < 256; i++) ref_fwd[i] = model_sbox(8'(i));
    for (int i = 0; i < 256; i++) ref_inv[ref_fwd[i]] = 8'(i);

    // reset held with valid traffic present
    rst_n = 1'b0;
    drive(1'b1, rnd128(), 1'b0);
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_state", state_out, 128'h0);
      chk("rst_vld", {127'h0, out_valid}, 128'h0);
      drive(1'b1, rnd128(), 1'b0);
    end
    rst_n = 1'b1;

    // known-answer vectors back-to-back
    drive(1'b1, V1_IN, 1'b0);
    step();
    chk("v1_state", state_out, V1_OUT);
    chk("v1_vld", {127'h0, out_valid}, 128'h1);
    drive(1'b1, V2_IN, 1'b0);
    step();
    chk("v2_state", state_out, V2_OUT);
    chk("v2_vld", {127'h0, out_valid}, 128'h1);

    // vector 1 then hold for 3 idle cycles with junk and X on state_in
    drive(1'b1, V1_IN, 1'b0);
    step();
    chk("v1b_state", state_out, V1_OUT);
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, (c == 1) ? 128'bx : rnd128(), 1'b0);
      step();
      chk("hold_state", state_out, V1_OUT);
      chk("hold_vld", {127'h0, out_valid}, 128'h0);
    end

    // endpoints
    drive(1'b1, 128'h0, 1'b0);
    step();
    chk("zero_in", state_out, {16{8'h63}});
    drive(1'b1, {16{8'hff}}, 1'b0);
    step();
    chk("ff_in", state_out, {16{8'h16}});

`ifdef SUB_BYTES_INV_EN
    drive(1'b1, V1_OUT, 1'b1);
    step();
    chk("inv_v1", state_out, V1_IN);
    drive(1'b1, {16{8'h63}}, 1'b1);
    step();
    chk("inv_63", state_out, 128'h0);
`endif

    // reset mid-stream: input presented during reset is discarded
    drive(1'b1, rnd128(), 1'b0);
    rst_n = 1'b0;
    step();
    chk("mid_rst_state", state_out, 128'h0);
    chk("mid_rst_vld", {127'h0, out_valid}, 128'h0);
    rst_n = 1'b1;
    drive(1'b0, rnd128(), 1'b0);
    step();
    chk("post_rst_idle", state_out, 128'h0);
    chk("post_rst_vld", {127'h0, out_valid}, 128'h0);

    // randomized stream against the reference model
    exp_state = 128'h0;
    exp_vld   = 1'b0;
    for (int c = 0; c < 300; c++) begin
      logic         v;
      logic         iv;
      logic [127:0] s;
      v = ($urandom_range(3) != 0);
      s = rnd128();
`ifdef SUB_BYTES_INV_EN
      iv = 1'($urandom_range(1));
`else
      iv = 1'b0;
`endif
      drive(v, s, iv);
      if (v) exp_state = model_state(s, iv);
      exp_vld = v;
      step();
      chk("rand_state", state_out, exp_state);
      chk("rand_vld", {127'h0, out_valid}, {127'h0, exp_vld});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
